// File: rtl/uart_receiver_pkg.sv
// Shared UART state definitions and small helpers used by the transmit and
// receive halves.
package uart_receiver_pkg;

    // Transmitter states; the names are kept unchanged for existing users.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Shifts one serial bit in at the MSB. Over eight bits sent LSB first, this
    // leaves the byte correctly ordered.
    function automatic logic [7:0] shift_in_msb(input logic [7:0] sr, input logic b);
        return {b, sr[7:1]};
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator for the receiver: a free-running divider that
// pulses tick for one clock each time it wraps. This is separate from the
// transmitter's bit-rate generator because it runs at OVERSAMPLE x baud.
module uart_rx_tick #(
    parameter int unsigned DIVISOR = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next divider count, and a tick on the wrap.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d  = {CW{1'b0}};
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider and registered tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive half. It accepts 8N1 frames (LSB first, idle high),
// oversampled at OVERSAMPLE ticks per bit. Each byte goes to a one-entry
// valid/ready register. Framing errors and overruns are reported as one-clock
// pulses. OVERSAMPLE must be even and at least 8, and the derived DIVISOR
// must be at least 1.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1600000,
    parameter int unsigned BAUD_RATE  = 100000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned SW      = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_SAMPLE  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);

    logic          tick;
    logic [1:0]    sync_q;
    logic          rxs;
    rx_state_e     state_q,      state_d;
    logic [SW-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]    bit_cnt_q,    bit_cnt_d;
    logic [7:0]    shift_q,      shift_d;
    logic [7:0]    data_q,       data_d;
    logic          valid_q,      valid_d;
    logic          frame_err_q,  frame_err_d;
    logic          overrun_q,    overrun_d;

    uart_rx_tick #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous serial line. It idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxs = sync_q[1];

    // Next state for the frame FSM, the counters, the shifter and the output register.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        // A handshake consumes the byte, except when the stop-bit logic below
        // reloads the register on the same edge.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    state_d      = RX_START;
                    sample_cnt_d = {SW{1'b0}};
                    bit_cnt_d    = 3'd0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (sample_cnt_q == MID_SAMPLE) begin
                        sample_cnt_d = {SW{1'b0}};
                        if (!rxs) begin
                            state_d = RX_DATA;
                        end else begin
                            state_d = RX_IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        sample_cnt_d = {SW{1'b0}};
                        shift_d      = shift_in_msb(shift_q, rxs);
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RX_STOP;
                        end else begin
                            state_d = RX_DATA;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        sample_cnt_d = {SW{1'b0}};
                        state_d      = RX_IDLE;   // back to IDLE at once so back-to-back frames work
                        if (rxs) begin
                            if (!valid_q || ready) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;   // keep the unconsumed byte, drop the new one
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RX_IDLE;
            sample_cnt_q <= {SW{1'b0}};
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver with the default parameters (16 clk per bit).
module tb_uart_receiver;

    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    logic [7:0] acc_q[$];
    int         acc_cyc_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         both_cnt = 0;

    uart_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: record accepted bytes and error pulses.
    always @(negedge clk) begin
        if (valid && ready) begin
            acc_q.push_back(data);
            acc_cyc_q.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] bv;
        bv = b;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(bv[i], BIT_CLKS);
        drive_bit(stop_bit, BIT_CLKS);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    int base, f0, o0, t0, d;

    initial begin
        rst   = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_ferr", 32'(frame_err), 32'h0);
        check_eq("rst_ovr", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(10);

        // Test 1: one good frame, 8'hA5.
        base = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check_eq("t1_count", 32'(acc_q.size() - base), 32'd1);
        if (acc_q.size() > base) begin
            check_eq("t1_data", 32'(acc_q[base]), 32'hA5);
            d = acc_cyc_q[base] - t0;
            check_eq("t1_latency_in_150_165", 32'(d >= 150 && d <= 165), 32'd1);
        end
        check_eq("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("t1_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Test 2: a 4-clk glitch must not produce output.
        base = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        drive_bit(1'b0, 4);
        idle(40);
        check_eq("t2_count", 32'(acc_q.size() - base), 32'd0);
        check_eq("t2_valid", 32'(valid), 32'h0);
        check_eq("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("t2_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Test 3: bad stop bit, then a good frame.
        base = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h3C, 1'b0);
        idle(30);
        check_eq("t3_ferr_one", 32'(ferr_cnt - f0), 32'd1);
        check_eq("t3_no_byte", 32'(acc_q.size() - base), 32'd0);
        check_eq("t3_valid", 32'(valid), 32'h0);
        send_frame(8'h11, 1'b1);
        idle(20);
        check_eq("t3_good_count", 32'(acc_q.size() - base), 32'd1);
        if (acc_q.size() > base) check_eq("t3_good_data", 32'(acc_q[base]), 32'h11);

        // Test 4: overrun while the consumer stalls.
        ready = 1'b0;
        base = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h12, 1'b1);
        idle(4);
        send_frame(8'h34, 1'b1);
        idle(20);
        @(negedge clk);
        check_eq("t4_valid", 32'(valid), 32'h1);
        check_eq("t4_data", 32'(data), 32'h12);
        check_eq("t4_ovr_one", 32'(ovr_cnt - o0), 32'd1);
        check_eq("t4_ferr", 32'(ferr_cnt - f0), 32'd0);
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t4_valid_cleared", 32'(valid), 32'h0);
        check_eq("t4_data_kept", 32'(data), 32'h12);
        check_eq("t4_accept_count", 32'(acc_q.size() - base), 32'd1);
        if (acc_q.size() > base) check_eq("t4_accept_data", 32'(acc_q[base]), 32'h12);
        @(posedge clk); #1;

        // Test 5: back-to-back frames with no idle gap.
        base = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check_eq("t5_count", 32'(acc_q.size() - base), 32'd2);
        if (acc_q.size() >= base + 2) begin
            check_eq("t5_first", 32'(acc_q[base]), 32'h00);
            check_eq("t5_second", 32'(acc_q[base+1]), 32'hFF);
        end
        check_eq("t5_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("t5_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Test 6: reset during the 4th data bit of 8'h5A, then a good frame.
        base = acc_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS / 2);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_data", 32'(data), 32'h00);
        check_eq("t6_rst_valid", 32'(valid), 32'h0);
        check_eq("t6_rst_ferr", 32'(frame_err), 32'h0);
        check_eq("t6_rst_ovr", 32'(overrun), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rx  = 1'b1;
        rst = 1'b1;
        idle(30);
        send_frame(8'hC3, 1'b1);
        idle(20);
        check_eq("t6_count", 32'(acc_q.size() - base), 32'd1);
        if (acc_q.size() > base) check_eq("t6_data", 32'(acc_q[base]), 32'hC3);
        check_eq("t6_ferr", 32'(ferr_cnt - f0), 32'd0);

        check_eq("never_both_errors", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Receive half of the UART. Consumes the serial line produced by the transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
Oversamples the line, recovers each byte and presents it on a one-entry valid/ready output register.
Flags framing errors and overruns to the host side.

Parameters:
CLK_FREQ, 1600000, system clock frequency in Hz
BAUD_RATE, 100000, line bit rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8
DIVISOR, CLK_FREQ/(BAUD_RATE*OVERSAMPLE), derived localparam; clocks per sample tick; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
rx  input  1  serial line, asynchronous to clk
data  output  8  received byte, stable while valid=1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid&&ready at a clk edge
frame_err  output  1  one-clk pulse: stop bit sampled 0
overrun  output  1  one-clk pulse: byte completed while previous still unconsumed

Behaviour:
- Reset (rst=0, async): state IDLE; data=8'h00, valid=0, frame_err=0, overrun=0; synchronizer flops=1; tick, sample and bit counters=0.
- rx passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value rxs, adding 2 clk of latency.
- Tick generator: counter 0..DIVISOR-1, free-running. tick=1 for one clk when it wraps.
- Sample counter: 0..OVERSAMPLE-1, advances on tick.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: when rxs=0, go to START; clear sample counter and bit counter.
- START: on the tick where sample count = OVERSAMPLE/2-1 (mid-bit):
  - rxs=0: go to DATA and restart the sample count.
  - rxs=1: treat as a glitch; return to IDLE with no output.
- DATA: on each tick where the sample count wraps OVERSAMPLE-1 -> 0 (one bit period after the previous mid-sample), shift rxs into bit 7 of the shift register (right shift, LSB first) and increment the bit counter.
  - After the 8th sample, go to STOP.
- STOP: one bit period after the last data sample, sample rxs, then go to IDLE in the same edge so back-to-back frames are supported.
  - rxs=1: byte completes (see output rules).
  - rxs=0: frame_err=1 for that clk; data and valid unchanged; no byte delivered.
- Output register rules, evaluated at the clk edge of the stop-bit sample:
  - valid=0: data<=shift register, valid<=1.
  - valid=1 and ready=1: old byte is consumed, new byte is loaded, valid stays 1, no overrun.
  - valid=1 and ready=0: new byte is dropped, data is kept, overrun=1 for one clk.
- At any other edge, valid&&ready clears valid. data keeps its last value.
- frame_err and overrun are never both 1.
- A frame that has an error does not affect valid.
- Reset asserted mid-frame aborts immediately. After release the block waits in IDLE for the next falling edge; no partial byte is output.
- A break (rx held low) gives frame_err once, then the FSM re-enters START and resamples. rx held low for the whole frame gives repeated frame_err pulses, one per frame time, with no deadlock.

Decomposition:
- Add RX_IDLE, RX_START, RX_DATA, RX_STOP to the shared states package as a separate rx_state enum. The transmitter state names stay unchanged.
- Oversample tick generation is one natural sub-module, uart_rx_tick.
  - Parameter: DIVISOR. Ports: clk, rst, tick.
  - Kept separate from the transmitter's bit-rate generator, because it runs at OVERSAMPLE x baud.
- Synchronizer, FSM, shift register and output register stay in uart_receiver.

Test Plan:
- Defaults (16 clk/bit), frame for 8'hA5 with ready=1 -> exactly one valid pulse with data=8'hA5, ~160 clk after the start edge; frame_err=0, overrun=0.
- rx low for 4 clk then high -> FSM returns to IDLE at the mid-start sample; valid, frame_err and overrun stay 0.
- Frame for 8'h3C with stop bit 0 -> frame_err one-clk pulse; valid stays 0; the next good frame 8'h11 delivers data=8'h11.
- ready=0, frames 8'h12 then 8'h34 -> valid=1 with data=8'h12; overrun pulse at the second stop sample; data still 8'h12. Raising ready clears valid.
- ready=1, back-to-back 8'h00 then 8'hFF with no idle gap -> two valid pulses, data 8'h00 then 8'hFF, no errors.
- rst=0 during the 4th data bit of 8'h5A, released, then frame 8'hC3 -> outputs are reset values during reset; only 8'hC3 is delivered.
